dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-master arbiter for the single data-memory port (RAM + switch/LED peripherals).
- Master 0 is the ARM core data port; master 1 is a secondary requester (loader/DMA/debug).
- Sits between the core and dmem in the top level.
- Registered ownership FSM, round-robin fairness, bounded burst length.
- Drives a stall to the core while the core is waiting.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 4, max consecutive granted transfers per owner while the other master waits (>=1)

Ports:
- clk  in  1  system clock
- nreset  in  1  synchronous active-low reset
- m0_req  in  1  core memory access request
- m0_we  in  1  core write enable
- m0_addr  in  AW  core address
- m0_wdata  in  DW  core write data
- m0_ack  out  1  core transfer performed this cycle
- m0_rdata  out  DW  read data to core
- m0_stall  out  1  core must hold request (m0_req & ~m0_ack)
- m1_req, m1_we, m1_addr, m1_wdata  in  1/1/AW/DW  secondary master, same meaning
- m1_ack  out  1  secondary transfer performed this cycle
- m1_rdata  out  DW  read data to master 1
- mem_we  out  1  to dmem MemWrite
- mem_addr  out  AW  to dmem address
- mem_wdata  out  DW  to dmem write data
- mem_rdata  in  DW  from dmem (combinational read)

Behaviour:
- Clock and reset: one clock, clk; nreset synchronous active-low.
- Reset state: owner=IDLE, burst_cnt=0, rr_last=M1 (M0 favoured first).
- Reset outputs: all acks 0, mem_we 0, mem_addr 0, mem_wdata 0.
- mem_we is gated by nreset, so no write is issued during a reset cycle.
- States: IDLE, OWN0, OWN1.
- Transfer rule: mx_ack = (owner==OWNx) & mx_req.
  - The memory mux selects the owner's addr/wdata.
  - mem_we = ack & owner's we.
  - IDLE drives mem_we=0, addr/wdata=0.
- Read data: mem_rdata is broadcast to both m0_rdata and m1_rdata; it is valid only when the matching ack is 1.
- Latency: a request raised in IDLE at cycle t is acked at t+1. An owner keeping req high is acked every cycle.
- Requester rule: a requester holds req/we/addr/wdata stable until ack. Each acked cycle is one complete transfer.
- Transitions are evaluated each clock:
  - IDLE, one req -> that master's state.
  - IDLE, both req -> the master other than rr_last.
  - OWNx, mx_req=0 -> OWNy if my_req, else IDLE.
  - OWNx, mx_req=1, my_req=0 -> stay. burst_cnt saturates; no forced release.
  - OWNx, mx_req=1, my_req=1, burst_cnt==MAX_BURST-1 -> OWNy.
  - OWNx, mx_req=1, my_req=1, otherwise -> stay and increment burst_cnt.
- burst_cnt: cleared on every ownership change and in IDLE. Width $clog2(MAX_BURST)+1.
- rr_last: updated to x whenever OWNx is entered.
- Starvation bound: a waiting master is granted within MAX_BURST+1 cycles of raising req.
- Handover: the switch cycle has no dead cycle. The last owner transfer is at cycle t and the new owner's ack is at t+1.
- Stall: m0_stall = m0_req & ~m0_ack, combinational. The core uses it to freeze its pipeline.
- Reset mid-burst: the in-flight transfer in the reset cycle is dropped (mem_we forced 0). The master must re-request.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs conflict_cnt[15:0] and m0_wait_cnt[15:0].
  - conflict_cnt increments on each cycle both reqs are high.
  - m0_wait_cnt increments on each cycle m0_stall is 1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t
  - master index localparams M0=0, M1=1
  - stats counter width STAT_W=16
- Sub-module: arb_rr_pick.
  - Small combinational next-owner selector.
  - Inputs: state, reqs, rr_last, burst_done. Output: next state.
  - Keeps the FSM register block trivial.
- The datapath mux stays in the top arbiter.

Test Plan:
1. Reset: hold nreset=0 with m0_req=1, m0_we=1 -> mem_we=0, acks=0. Release -> m0_ack=1 on the first cycle after release.
2. Single core read: m0_req=1, addr=0x40, mem_rdata=0xDEADBEEF -> m0_ack at t+1, m0_rdata=0xDEADBEEF, m0_stall=1 at t and 0 at t+1.
3. Simultaneous from IDLE after reset: both req -> OWN0 first (rr_last=M1). With both held, M0 gets 4 acks, then M1 gets 4 acks, alternating. m1 wait never exceeds 5 cycles.
4. Write passthrough: m1_we=1, addr=0x80, wdata=0x0000_03FF -> mem_we=1, mem_addr=0x80, mem_wdata=0x3FF exactly on the m1_ack cycle. m0 signals are ignored.
5. Early release: M0 owns with burst_cnt=1 and drops req while m1_req=1 -> m1_ack next cycle, burst_cnt=0.
6. With DMEM_ARB_STATS_EN: 10 cycles of dual requests -> conflict_cnt=10, m0_wait_cnt equals the observed stall cycles. Force 70000 conflict cycles -> saturates at 0xFFFF.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// The DMEM_ARB_STATS_EN build of dmem_arbiter uses STAT_W for its counters.
package dmem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int STAT_W = 16;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Next-owner selector for dmem_arbiter: round-robin from IDLE, burst-limited
// handover while owned. Purely combinational.
module arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  arb_state_t i_state,
    input  logic [1:0] i_req,
    input  logic       i_rr_last,
    input  logic       i_burst_done,
    output arb_state_t o_next
);

    always_comb begin
        o_next = ARB_IDLE;
        case (i_state)
            ARB_IDLE: begin
                if (&i_req)
                    o_next = (i_rr_last == M1) ? ARB_OWN0 : ARB_OWN1;
                else if (i_req[M0])
                    o_next = ARB_OWN0;
                else if (i_req[M1])
                    o_next = ARB_OWN1;
            end
            ARB_OWN0: begin
                if (!i_req[M0])
                    o_next = i_req[M1] ? ARB_OWN1 : ARB_IDLE;
                else if (i_req[M1] && i_burst_done)
                    o_next = ARB_OWN1;
                else
                    o_next = ARB_OWN0;
            end
            ARB_OWN1: begin
                if (!i_req[M1])
                    o_next = i_req[M0] ? ARB_OWN0 : ARB_IDLE;
                else if (i_req[M0] && i_burst_done)
                    o_next = ARB_OWN0;
                else
                    o_next = ARB_OWN1;
            end
            default: o_next = ARB_IDLE;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port (core + secondary master).
// Define DMEM_ARB_STATS_EN to add saturating conflict/stall counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_stall,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] conflict_cnt,
    output logic [STAT_W-1:0] m0_wait_cnt
`endif
);

    localparam int            CW         = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [CW-1:0] r_burst_cnt;
    logic          r_rr_last;
    logic          w_burst_done;
    logic          w_ack0;
    logic          w_ack1;

    assign w_burst_done = (r_burst_cnt == BURST_LAST);

    arb_rr_pick u_pick (
        .i_state     (r_state),
        .i_req       ({m1_req, m0_req}),
        .i_rr_last   (r_rr_last),
        .i_burst_done(w_burst_done),
        .o_next      (w_next)
    );

    // Count saturates at BURST_LAST so a solo owner hands over on the first
    // contested cycle once it has used its share.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= ARB_IDLE;
            r_burst_cnt <= '0;
            r_rr_last   <= M1;
        end else begin
            r_state <= w_next;
            if (w_next == ARB_IDLE || w_next != r_state)
                r_burst_cnt <= '0;
            else if (!w_burst_done)
                r_burst_cnt <= r_burst_cnt + CW'(1);
            if (w_next != r_state) begin
                if (w_next == ARB_OWN0)
                    r_rr_last <= M0;
                else if (w_next == ARB_OWN1)
                    r_rr_last <= M1;
            end
        end
    end

    // Gating with nreset drops any in-flight transfer during a reset cycle.
    assign w_ack0 = nreset & (r_state == ARB_OWN0) & m0_req;
    assign w_ack1 = nreset & (r_state == ARB_OWN1) & m1_req;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (nreset) begin
            case (r_state)
                ARB_OWN0: begin
                    mem_addr  = m0_addr;
                    mem_wdata = m0_wdata;
                end
                ARB_OWN1: begin
                    mem_addr  = m1_addr;
                    mem_wdata = m1_wdata;
                end
                default: ;
            endcase
        end
    end

    assign mem_we   = (w_ack0 & m0_we) | (w_ack1 & m1_we);
    assign m0_ack   = w_ack0;
    assign m1_ack   = w_ack1;
    assign m0_stall = m0_req & ~w_ack0;
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_conflict_cnt;
    logic [STAT_W-1:0] r_m0_wait_cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_conflict_cnt <= '0;
            r_m0_wait_cnt  <= '0;
        end else begin
            if (m0_req && m1_req && r_conflict_cnt != '1)
                r_conflict_cnt <= r_conflict_cnt + STAT_W'(1);
            if (m0_stall && r_m0_wait_cnt != '1)
                r_m0_wait_cnt <= r_m0_wait_cnt + STAT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign m0_wait_cnt  = r_m0_wait_cnt;
`endif

endmodule
